// File: rtl/ep_dec_pkg.sv
// Shared types and constants for the CABAC bypass-bin decoder.
// Holds the FSM encoding, range bounds and the range scaling helper.
package ep_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ep_state_t;

    localparam int unsigned RANGE_SHIFT = 7;
    localparam logic [8:0]  RANGE_MIN   = 9'd256;
    localparam logic [8:0]  RANGE_MAX   = 9'd510;

    // Bypass comparisons are made against the range aligned to m_value precision.
    function automatic logic [15:0] scaled_range(input logic [8:0] range);
        return 16'(range) << RANGE_SHIFT;
    endfunction

endpackage

// File: rtl/ep_bin_stage.sv
// One equiprobable bin: shift in a bitstream bit, compare against scaledRange.
// Purely combinational so several stages can be chained within one clock.
module ep_bin_stage #(
    parameter int VALUE_W = 16
) (
    input  logic [VALUE_W-1:0] i_value,
    input  logic [VALUE_W-1:0] i_scaled,
    input  logic               i_bit,
    output logic [VALUE_W-1:0] o_value_next,
    output logic               o_bin
);

    logic [VALUE_W:0] w_shift;
    logic [VALUE_W:0] w_diff;
    logic             w_ge;

    assign w_shift      = {i_value, i_bit};
    assign w_ge         = (w_shift >= {1'b0, i_scaled});
    assign w_diff       = w_shift - {1'b0, i_scaled};
    assign o_bin        = w_ge;
    assign o_value_next = w_ge ? w_diff[VALUE_W-1:0] : w_shift[VALUE_W-1:0];

endmodule

// File: rtl/ep_bins_decoder.sv
// Multi-cycle CABAC bypass-bin decoder: up to BINS_PER_CYCLE chained EP stages
// per clock, accumulating up to MAX_BINS bins per command.
module ep_bins_decoder
    import ep_dec_pkg::*;
#(
    parameter int BINS_PER_CYCLE = 4,
    parameter int MAX_BINS       = 32,
    parameter int VALUE_W        = 16,
    parameter int CNT_W          = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CNT_W-1:0]          cmd_num_bins,
    input  logic [8:0]                cmd_range,
    input  logic [VALUE_W-1:0]        cmd_value,
    input  logic                      bits_valid,
    input  logic [BINS_PER_CYCLE-1:0] bits_in,
    output logic [CNT_W-1:0]          bits_consume,
    output logic                      done_valid,
    input  logic                      done_ready,
    output logic [MAX_BINS-1:0]       bins_out,
    output logic [VALUE_W-1:0]        value_out,
    output logic                      err_out
);

    ep_state_t           r_state;
    logic [VALUE_W-1:0]  r_scaled;
    logic [VALUE_W-1:0]  r_value;
    logic [MAX_BINS-1:0] r_acc;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_err;

    logic [VALUE_W-1:0]        w_scaled_in;
    logic [CNT_W-1:0]          w_num_clamped;
    logic [CNT_W-1:0]          w_k;
    logic                      w_run_go;
    logic [VALUE_W-1:0]        w_val [BINS_PER_CYCLE+1];
    logic [BINS_PER_CYCLE-1:0] w_bin;
    logic [MAX_BINS-1:0]       w_acc_next;
    logic [VALUE_W-1:0]        w_value_next;

    assign w_scaled_in   = VALUE_W'(scaled_range(cmd_range));
    assign w_num_clamped = (cmd_num_bins > CNT_W'(MAX_BINS)) ? CNT_W'(MAX_BINS) : cmd_num_bins;
    assign w_k           = (r_remaining > CNT_W'(BINS_PER_CYCLE)) ? CNT_W'(BINS_PER_CYCLE) : r_remaining;
    assign w_run_go      = (r_state == ST_RUN) && bits_valid;

    assign w_val[0] = r_value;

    // Stage i consumes bits_in[BPC-1-i], so the MSB of the bit window is decoded first.
    for (genvar gi = 0; gi < BINS_PER_CYCLE; gi++) begin : g_stage
        ep_bin_stage #(.VALUE_W(VALUE_W)) u_stage (
            .i_value      (w_val[gi]),
            .i_scaled     (r_scaled),
            .i_bit        (bits_in[BINS_PER_CYCLE-1-gi]),
            .o_value_next (w_val[gi+1]),
            .o_bin        (w_bin[gi])
        );
    end

    // Merge only the first k stage results into the accumulator and value.
    always_comb begin
        w_acc_next   = r_acc;
        w_value_next = r_value;
        for (int i = 0; i < BINS_PER_CYCLE; i++) begin
            w_acc_next   = (CNT_W'(i) < w_k) ? {w_acc_next[MAX_BINS-2:0], w_bin[i]} : w_acc_next;
            w_value_next = (CNT_W'(i) < w_k) ? w_val[i+1] : w_value_next;
        end
    end

    // Command sequencing and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_scaled    <= {VALUE_W{1'b0}};
            r_value     <= {VALUE_W{1'b0}};
            r_acc       <= {MAX_BINS{1'b0}};
            r_remaining <= {CNT_W{1'b0}};
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_scaled    <= w_scaled_in;
                        r_value     <= cmd_value;
                        r_acc       <= {MAX_BINS{1'b0}};
                        r_remaining <= w_num_clamped;
                        r_err       <= (cmd_range < RANGE_MIN) || (cmd_value >= w_scaled_in);
                        r_state     <= (w_num_clamped == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bits_valid) begin
                        r_acc       <= w_acc_next;
                        r_value     <= w_value_next;
                        r_remaining <= r_remaining - w_k;
                        r_state     <= (r_remaining == w_k) ? ST_DONE : ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (r_state == ST_IDLE);
    assign done_valid   = (r_state == ST_DONE);
    assign bits_consume = (w_run_go && !rst) ? w_k : {CNT_W{1'b0}};
    assign bins_out     = r_acc;
    assign value_out    = r_value;
    assign err_out      = r_err;

endmodule

// File: tb/tb_ep_bins_decoder.sv
// Directed bench for ep_bins_decoder with hand-computed bypass-decode results.
module tb_ep_bins_decoder;

    localparam int BPC     = 4;
    localparam int MAXB    = 32;
    localparam int VALUE_W = 16;
    localparam int CNT_W   = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CNT_W-1:0]   cmd_num_bins;
    logic [8:0]         cmd_range;
    logic [VALUE_W-1:0] cmd_value;
    logic               bits_valid;
    logic [BPC-1:0]     bits_in;
    logic [CNT_W-1:0]   bits_consume;
    logic               done_valid;
    logic               done_ready;
    logic [MAXB-1:0]    bins_out;
    logic [VALUE_W-1:0] value_out;
    logic               err_out;

    int total = 0;
    int bad   = 0;

    ep_bins_decoder #(
        .BINS_PER_CYCLE(BPC), .MAX_BINS(MAXB), .VALUE_W(VALUE_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_bins(cmd_num_bins),
        .cmd_range(cmd_range), .cmd_value(cmd_value),
        .bits_valid(bits_valid), .bits_in(bits_in), .bits_consume(bits_consume),
        .done_valid(done_valid), .done_ready(done_ready),
        .bins_out(bins_out), .value_out(value_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; returns one cycle after acceptance.
    task automatic issue(input logic [8:0] range, input logic [VALUE_W-1:0] value, input logic [CNT_W-1:0] n);
        cmd_valid    = 1'b1;
        cmd_range    = range;
        cmd_value    = value;
        cmd_num_bins = n;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic retire();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        #1;
        chk("ready_after_done", cmd_ready, 1'b1);
        chk("done_dropped", done_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_num_bins = '0; cmd_range = 9'd0; cmd_value = '0;
        bits_valid = 1'b0; bits_in = '0; done_ready = 1'b0;
        tick(); tick();
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_bins", bins_out, 32'h0);
        chk("rst_value", value_out, 16'h0);
        chk("rst_err", err_out, 1'b0);
        chk("rst_consume", bits_consume, 6'd0);
        rst = 1'b0;
        tick();

        // T1: value grows 1,3,7,15 below 32768, all bins zero
        bits_valid = 1'b1; bits_in = 4'hF;
        issue(9'd256, 16'd0, 6'd4);
        chk("t1_consume", bits_consume, 6'd4);
        chk("t1_not_done", done_valid, 1'b0);
        tick();
        chk("t1_done", done_valid, 1'b1);
        chk("t1_bins", bins_out, 32'h0);
        chk("t1_value", value_out, 16'd15);
        chk("t1_err", err_out, 1'b0);
        chk("t1_consume_done", bits_consume, 6'd0);
        retire();

        // T2: value saturates at 32767, every bin one
        issue(9'd256, 16'd32767, 6'd8);
        chk("t2_consume_a", bits_consume, 6'd4);
        tick();
        chk("t2_consume_b", bits_consume, 6'd4);
        chk("t2_not_done", done_valid, 1'b0);
        tick();
        chk("t2_done", done_valid, 1'b1);
        chk("t2_bins", bins_out, 32'hFF);
        chk("t2_value", value_out, 16'd32767);
        retire();

        // T3: 16384*2 = scaledRange exactly -> first bin one, then zeros
        bits_in = 4'h0;
        issue(9'd256, 16'd16384, 6'd4);
        tick();
        chk("t3_done", done_valid, 1'b1);
        chk("t3_bins", bins_out, 32'h8);
        chk("t3_value", value_out, 16'd0);
        retire();

        // T4: n=6 with a 3-cycle feeder stall; bins 1001 then 11, value 2091
        bits_in = 4'b1010;
        issue(9'd256, 16'd20000, 6'd6);
        chk("t4_consume_4", bits_consume, 6'd4);
        tick();
        bits_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_consume_stall", bits_consume, 6'd0);
            chk("t4_stall_not_done", done_valid, 1'b0);
            tick();
        end
        bits_valid = 1'b1; bits_in = 4'b1100;
        #1;
        chk("t4_consume_2", bits_consume, 6'd2);
        tick();
        chk("t4_done", done_valid, 1'b1);
        chk("t4_bins", bins_out, 32'h27);
        chk("t4_value", value_out, 16'd2091);
        retire();

        bits_in = 4'b1010;
        issue(9'd256, 16'd20000, 6'd6);
        tick();
        bits_in = 4'b1100;
        #1;
        chk("t4u_consume_2", bits_consume, 6'd2);
        tick();
        chk("t4u_bins", bins_out, 32'h27);
        chk("t4u_value", value_out, 16'd2091);
        retire();

        // T5a: n=0 finishes immediately with the input value
        bits_in = 4'hF;
        issue(9'd300, 16'd1234, 6'd0);
        chk("t5a_done", done_valid, 1'b1);
        chk("t5a_bins", bins_out, 32'h0);
        chk("t5a_value", value_out, 16'd1234);
        chk("t5a_err", err_out, 1'b0);
        chk("t5a_consume", bits_consume, 6'd0);
        retire();

        // T5b: n=40 clamps to 32; 15 zero bins then 17 one bins
        issue(9'd256, 16'd0, 6'd40);
        for (int i = 0; i < 8; i++) begin
            chk("t5b_consume", bits_consume, 6'd4);
            chk("t5b_not_done", done_valid, 1'b0);
            tick();
        end
        chk("t5b_done", done_valid, 1'b1);
        chk("t5b_bins", bins_out, 32'h0001FFFF);
        chk("t5b_value", value_out, 16'd32767);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5b_hold_done", done_valid, 1'b1);
            chk("t5b_hold_bins", bins_out, 32'h0001FFFF);
            chk("t5b_hold_value", value_out, 16'd32767);
            chk("t5b_hold_ready", cmd_ready, 1'b0);
        end
        retire();

        // T6: illegal value and illegal range both flag err_out
        issue(9'd256, 16'd40000, 6'd4);
        tick();
        chk("t6_done", done_valid, 1'b1);
        chk("t6_err_value", err_out, 1'b1);
        retire();
        issue(9'd255, 16'd0, 6'd4);
        tick();
        chk("t6_err_range", err_out, 1'b1);
        retire();

        // T6b: reset mid-RUN aborts without consuming bits
        issue(9'd256, 16'd0, 6'd32);
        chk("t6b_consume_run", bits_consume, 6'd4);
        tick();
        rst = 1'b1;
        #1;
        chk("t6b_consume_in_rst", bits_consume, 6'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6b_ready", cmd_ready, 1'b1);
        chk("t6b_done", done_valid, 1'b0);
        chk("t6b_consume_idle", bits_consume, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
